// File: rtl/palette_pkg.sv
// Shared definitions for the programmable colour palette: the default VDG
// colour set, the restore FSM states and the RGB component width.
package palette_pkg;

    // Width of one colour component (R, G or B)
    localparam int COMP_W     = 3;
    // Width of one default table entry: R,G,B packed MSB-first
    localparam int DEF_W      = 3 * COMP_W;
    // Number of entries in the built-in default table
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_IDX_W  = 4;

    // Default VDG colour set; the last four entries are black
    localparam logic [DEF_W-1:0] DEFAULT_RGB [DEF_DEPTH] = '{
        9'h000, 9'h078, 9'h1F8, 9'h08F,
        9'h182, 9'h1FF, 9'h07C, 9'h1CF,
        9'h1E0, 9'h1F2, 9'h018, 9'h0C0,
        9'h000, 9'h000, 9'h000, 9'h000
    };

    // Restore sequencer states
    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    // Default colour for a palette slot. Slots beyond the built-in table and
    // all slots when defaults are disabled come back black.
    function automatic logic [DEF_W-1:0] default_colour(input int idx, input bit enable);
        logic [DEF_W-1:0] colour;
        colour = '0;
        if (enable && idx >= 0 && idx < DEF_DEPTH) begin
            colour = DEFAULT_RGB[idx[DEF_IDX_W-1:0]];
        end
        return colour;
    endfunction

endpackage

// File: rtl/palette_regfile.sv
// Palette storage: one register per colour index, loaded with the default
// table by the asynchronous reset, one write port and two independent
// combinational read ports (pixel lookup and CPU readback). Reads see the
// contents before any write landing on the same edge.
module palette_regfile
    import palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int RGB_W      = 9,
    parameter bit DEFAULT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [RGB_W-1:0] wr_data,
    input  logic [IDX_W-1:0] pix_addr,
    output logic [RGB_W-1:0] pix_data,
    input  logic [IDX_W-1:0] cpu_addr,
    output logic [RGB_W-1:0] cpu_data
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [RGB_W-1:0] mem [DEPTH];

    // Reset value of one slot, resized to the output colour width
    function automatic logic [RGB_W-1:0] init_value(input int idx);
        return RGB_W'(default_colour(idx, DEFAULT_EN));
    endfunction

    // Storage: async reset reloads the whole default table, else single write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= init_value(i);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read ports are plain muxes on the current contents
    assign pix_data = mem[pix_addr];
    assign cpu_data = mem[cpu_addr];

endmodule

// File: rtl/palette_lut.sv
// Programmable colour palette for the video output path. A pixel colour
// index is mapped to RGB through a CPU-writable palette in a two-stage
// registered pipeline with blanking and border selection. A restore pulse
// walks the palette one entry per clock, reloading the default colour set
// while the pixel path keeps running.
module palette_lut
    import palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int RGB_W      = 9,
    parameter bit DEFAULT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] pix_index,
    input  logic             blank,
    input  logic             border_en,
    input  logic [IDX_W-1:0] border_index,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [RGB_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [RGB_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             restore,
    output logic             busy,
    output logic [RGB_W-1:0] rgb_out,
    output logic             rgb_valid
);

    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Restore sequencer
    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             cnt_done;

    // Palette write port after arbitration between restore and CPU
    logic             rf_wr_en;
    logic [IDX_W-1:0] rf_wr_addr;
    logic [RGB_W-1:0] rf_wr_data;

    // Palette read data
    logic [RGB_W-1:0] pix_colour;
    logic [RGB_W-1:0] cpu_colour;

    // Pixel pipeline stage 1 registers
    logic [IDX_W-1:0] sel_idx_p1;
    logic             blank_p1;
    logic             vld_p1;

    // Last slot of the sweep; the counter itself never wraps back to 0
    assign cnt_done = (cnt == LAST_IDX);

    // Restore value for the slot currently addressed by the sequencer
    function automatic logic [RGB_W-1:0] restore_value(input logic [IDX_W-1:0] idx);
        return RGB_W'(default_colour(int'({1'b0, idx}), DEFAULT_EN));
    endfunction

    // Write arbitration: restore owns the port; CPU writes while busy are dropped
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = wr_addr;
        rf_wr_data = wr_data;
        if (state == RESTORE) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = cnt;
            rf_wr_data = restore_value(cnt);
        end else if (wr_en) begin
            rf_wr_en   = 1'b1;
        end
    end

    palette_regfile #(
        .IDX_W      (IDX_W),
        .RGB_W      (RGB_W),
        .DEFAULT_EN (DEFAULT_EN)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (rf_wr_en),
        .wr_addr  (rf_wr_addr),
        .wr_data  (rf_wr_data),
        .pix_addr (sel_idx_p1),
        .pix_data (pix_colour),
        .cpu_addr (rd_addr),
        .cpu_data (cpu_colour)
    );

    // Restore FSM: one palette slot per clock; restore pulses mid-sweep are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (restore) begin
                        state <= RESTORE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RESTORE: begin
                    if (cnt_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage 1: select border or pixel index, capture blank and valid ----
    // Stage 1 control flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            blank_p1 <= blank;
            vld_p1   <= pix_valid | border_en;
        end
    end

    // Stage 1 index; only observed when vld_p1 is set, so no reset needed
    always_ff @(posedge clk) begin
        sel_idx_p1 <= border_en ? border_index : pix_index;
    end

    // ---- stage 2: palette lookup, blanking, registered DAC drive ----
    // Output black when blanked or outside active/border area
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_out   <= (blank_p1 || !vld_p1) ? '0 : pix_colour;
            rgb_valid <= vld_p1 & ~blank_p1;
        end
    end

    // CPU readback: data held between reads, valid pulses for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= cpu_colour;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// Bench for palette_lut: directed scenarios with hand-computed values, then
// randomized traffic, all continuously compared against a behavioural
// palette model.
module tb_palette_lut;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pix_valid = 1'b0;
    logic [3:0] pix_index = '0;
    logic       blank = 1'b0;
    logic       border_en = 1'b0;
    logic [3:0] border_index = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [8:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic       restore = 1'b0;
    logic       busy;
    logic [8:0] rgb_out;
    logic       rgb_valid;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    logic [8:0] def_tbl [16] = '{
        9'h000, 9'h078, 9'h1F8, 9'h08F, 9'h182, 9'h1FF, 9'h07C, 9'h1CF,
        9'h1E0, 9'h1F2, 9'h018, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h000
    };

    palette_lut #(.IDX_W(4), .RGB_W(9), .DEFAULT_EN(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_valid    (pix_valid),
        .pix_index    (pix_index),
        .blank        (blank),
        .border_en    (border_en),
        .border_index (border_index),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .restore      (restore),
        .busy         (busy),
        .rgb_out      (rgb_out),
        .rgb_valid    (rgb_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: palette contents, pending pixel lookup, restore countdown
    logic [8:0] m_pal [16];
    logic [3:0] m_sel;
    logic       m_blank, m_vld;
    logic [4:0] m_left;
    logic [3:0] m_idx;
    logic [8:0] e_rgb, e_rd;
    logic       e_rgbv, e_rdv, e_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_pal[i] <= def_tbl[i];
            m_sel   <= '0;
            m_blank <= 1'b0;
            m_vld   <= 1'b0;
            m_left  <= '0;
            m_idx   <= '0;
            e_rgb   <= '0;
            e_rgbv  <= 1'b0;
            e_rd    <= '0;
            e_rdv   <= 1'b0;
            e_busy  <= 1'b0;
        end else begin
            // colour of the pixel presented one cycle ago, from today's palette
            e_rgb  <= (m_blank || !m_vld) ? 9'h000 : m_pal[m_sel];
            e_rgbv <= m_vld && !m_blank;
            m_sel   <= border_en ? border_index : pix_index;
            m_blank <= blank;
            m_vld   <= pix_valid || border_en;
            e_rdv <= rd_en;
            if (rd_en) e_rd <= m_pal[rd_addr];
            if (m_left != 5'd0) begin
                m_pal[m_idx] <= def_tbl[m_idx];
                m_idx  <= m_idx + 4'd1;
                m_left <= m_left - 5'd1;
            end else begin
                if (wr_en) m_pal[wr_addr] <= wr_data;
                if (restore) begin
                    m_left <= 5'd16;
                    m_idx  <= 4'd0;
                end
            end
            e_busy <= (m_left > 5'd1) || (m_left == 5'd0 && restore);
        end
    end

    // Continuous compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rgb_out",   32'(rgb_out),   32'(e_rgb));
            check("m_rgb_valid", 32'(rgb_valid), 32'(e_rgbv));
            check("m_rd_data",   32'(rd_data),   32'(e_rd));
            check("m_rd_valid",  32'(rd_valid),  32'(e_rdv));
            check("m_busy",      32'(busy),      32'(e_busy));
        end
    end

    initial begin : stim
        int busy_cycles;
        logic [8:0] exp4 [4];
        exp4 = '{9'h078, 9'h1F8, 9'h08F, 9'h182};

        #1 reset_n = 1'b0;
        #11;
        check("rst_rgb_out",   32'(rgb_out),   32'h0);
        check("rst_rgb_valid", 32'(rgb_valid), 32'h0);
        check("rst_rd_data",   32'(rd_data),   32'h0);
        check("rst_rd_valid",  32'(rd_valid),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        step(1);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Default lookup, two-clock latency
        pix_valid = 1'b1; pix_index = 4'd3;
        step(2);
        check("lut_idx3", 32'(rgb_out), 32'h08F);
        check("lut_idx3_v", 32'(rgb_valid), 32'h1);
        pix_index = 4'd0;
        step(2);
        check("lut_idx0", 32'(rgb_out), 32'h000);
        check("lut_idx0_v", 32'(rgb_valid), 32'h1);

        // Write collides with a stage-2 lookup of the same entry
        pix_index = 4'd3;
        step(1);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 9'h155;
        step(1);
        wr_en = 1'b0;
        check("wr_old_08f", 32'(rgb_out), 32'h08F);
        step(1);
        check("wr_new_155", 32'(rgb_out), 32'h155);

        // Blanking and border
        blank = 1'b1; pix_index = 4'd5;
        step(2);
        check("blank_rgb", 32'(rgb_out), 32'h000);
        check("blank_v", 32'(rgb_valid), 32'h0);
        blank = 1'b0; pix_valid = 1'b0; border_en = 1'b1; border_index = 4'd8;
        step(2);
        check("border_rgb", 32'(rgb_out), 32'h1E0);
        check("border_v", 32'(rgb_valid), 32'h1);
        border_en = 1'b0;

        // Overwrite 1..4, then restore with dropped write and ignored re-trigger
        for (int a = 1; a <= 4; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 9'($urandom_range(0, 511));
            step(1);
        end
        wr_en = 1'b0;
        restore = 1'b1;
        step(1);
        restore = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            wr_en   = (i == 2);
            wr_addr = 4'd2; wr_data = 9'h1AB;
            restore = (i == 5);
            step(1);
        end
        wr_en = 1'b0; restore = 1'b0;
        check("restore_busy_len", 32'(busy_cycles), 32'd16);
        for (int a = 1; a <= 4; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step(1);
            rd_en = 1'b0;
            check("restore_rd_data", 32'(rd_data), 32'(exp4[a-1]));
            check("restore_rd_v1", 32'(rd_valid), 32'h1);
            step(1);
            check("restore_rd_v0", 32'(rd_valid), 32'h0);
        end

        // Reset in the middle of a restore sweep
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 9'h0AA;
        step(1);
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd12;
        step(1);
        rd_en = 1'b0;
        check("e12_written", 32'(rd_data), 32'h0AA);
        pix_valid = 1'b1; pix_index = 4'd3;
        restore = 1'b1;
        step(1);
        restore = 1'b0;
        step(6);
        check("midrst_busy_pre", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rgb_out", 32'(rgb_out), 32'h0);
        check("midrst_rgb_valid", 32'(rgb_valid), 32'h0);
        check("midrst_rd_data", 32'(rd_data), 32'h0);
        check("midrst_rd_valid", 32'(rd_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        step(1);
        reset_n = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd12;
        step(1);
        rd_en = 1'b0;
        check("midrst_e12", 32'(rd_data), 32'h000);
        check("midrst_e12_v", 32'(rd_valid), 32'h1);

        // Back-to-back sweep of the default table
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) pix_index = 4'(i);
            else pix_valid = 1'b0;
            step(1);
            if (i >= 1) begin
                check("sweep_rgb", 32'(rgb_out), 32'(def_tbl[i-1]));
                check("sweep_v", 32'(rgb_valid), 32'h1);
            end
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            pix_valid    = ($urandom_range(0, 3) != 0);
            pix_index    = 4'($urandom_range(0, 15));
            blank        = ($urandom_range(0, 7) == 0);
            border_en    = ($urandom_range(0, 5) == 0);
            border_index = 4'($urandom_range(0, 15));
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_addr      = 4'($urandom_range(0, 15));
            wr_data      = 9'($urandom_range(0, 511));
            rd_en        = ($urandom_range(0, 2) == 0);
            rd_addr      = 4'($urandom_range(0, 15));
            restore      = ($urandom_range(0, 96) == 0);
            step(1);
        end
        pix_valid = 1'b0; blank = 1'b0; border_en = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; restore = 1'b0;
        step(20);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
